v_multiplexers_hold_reg: RTL and testbench
==========================================

// Module: v_multiplexers_hold_reg
//
// PURPOSE
//  Parametrised, registered N-channel multiplexer with an explicit hold register.
//  Unmapped select codes keep the previous output in a flip-flop, never a latch.
//  Sits between channel sources and one consumer; valid/ready on both sides.
//  Counts unmapped-select transfers for debug.
//
// PARAMETERS
//  W         8   data width per channel (>=1)
//  NCH       3   number of input channels (>=2)
//  SW        2   select width; 2**SW >= NCH required (elaboration error otherwise)
//  RESET_VAL 0   value of O after reset (W bits)
//  CW        8   width of MISS_CNT (>=1)
//
// PORTS
//  C         in   1       clock, all state on rising edge
//  CLR       in   1       asynchronous reset, active-high
//  DI        in   NCH*W   packed inputs; channel k = DI[k*W +: W]
//  S         in   SW      channel select, sampled with DI on accept
//  I_VALID   in   1       upstream presents DI/S
//  I_READY   out  1       block can accept this cycle
//  O         out  W       registered mux output
//  O_VALID   out  1       O holds an unconsumed result
//  O_READY   in   1       downstream consumes O this cycle
//  O_HOLD    out  1       1 = current O is a held value (S was unmapped)
//  MISS_CNT  out  CW      saturating count of accepted unmapped selects
//
// BEHAVIOUR
//  - Reset (CLR=1, async, any time): O=RESET_VAL, O_VALID=0, O_HOLD=0, MISS_CNT=0.
//    In-flight result is discarded. First accept is possible on the first edge
//    after CLR falls.
//  - I_READY = !O_VALID | O_READY (combinational). Full throughput: one
//    transfer per cycle when O_READY is held high.
//  - Accept = I_VALID & I_READY. On accept, latency is 1 cycle:
//      * S < NCH:  O <= DI[S*W +: W], O_HOLD <= 0.
//      * S >= NCH: O unchanged, O_HOLD <= 1,
//                  MISS_CNT <= MISS_CNT+1, saturating at all-ones (no wrap).
//      * O_VALID <= 1 in both cases. A held result is still a transfer.
//  - No accept and O_READY=1: O_VALID <= 0. O and O_HOLD keep their values.
//  - O_VALID=1 & O_READY=0 (stall): O, O_HOLD and O_VALID stay stable.
//    I_READY=0, so DI and S are ignored.
//  - Simultaneous consume and accept in one cycle: the new result replaces the
//    old one, and O_VALID stays 1.
//  - A hold after reset yields O=RESET_VAL.
//  - When NCH = 2**SW, the unmapped path is unreachable. MISS_CNT then stays 0.
//  - No combinational path from DI or S to O. O_READY -> I_READY is the only
//    combinational path.
//  - No latches. Every register has a defined value on every clock.
//
// TESTING
//  1. Reset: assert CLR mid-transfer with O_VALID=1 -> O=RESET_VAL, O_VALID=0,
//     O_HOLD=0 and MISS_CNT=0 immediately, before any clock edge.
//  2. Defaults, O_READY=1, DI={8'h33,8'h22,8'h11}, I_VALID=1 for 3 cycles with S=0,1,2
//     -> O=11,22,33 on the following cycles, O_VALID=1, O_HOLD=0, I_READY=1.
//  3. After O=22, accept S=3 -> O stays 22, O_HOLD=1, MISS_CNT=1.
//     Then S=0 -> O=11, O_HOLD=0.
//  4. Stall: O_READY=0 for 4 cycles with I_VALID=1 and changing DI/S ->
//     I_READY=0, O stable. On release, the next DI is accepted in the same cycle.
//  5. CW=2, 5 accepts with S=3 -> MISS_CNT = 1,2,3,3,3 (saturates).
//  6. Random valid/ready, W=16, NCH=5, SW=3 -> scoreboard match on every
//     O_VALID&O_READY, no lost or duplicated transfers, MISS_CNT = unmapped count.

Source files
------------

// File: rtl/v_multiplexers_hold_reg.sv
// Registered N-channel mux with a hold register. Select codes that map to no channel re-issue the previous output.
// Latency is 1 cycle. I_READY = !O_VALID | O_READY. During a stall O is frozen and inputs are ignored.
module v_multiplexers_hold_reg #(
  parameter int             W         = 8,
  parameter int             NCH       = 3,
  parameter int             SW        = 2,
  parameter logic [W-1:0]   RESET_VAL = '0,
  parameter int             CW        = 8
) (
  input  logic              C,
  input  logic              CLR,
  input  logic [NCH*W-1:0]  DI,
  input  logic [SW-1:0]     S,
  input  logic              I_VALID,
  output logic              I_READY,
  output logic [W-1:0]      O,
  output logic              O_VALID,
  input  logic              O_READY,
  output logic              O_HOLD,
  output logic [CW-1:0]     MISS_CNT
);

  generate
    if ((1 << SW) < NCH) begin : g_sw_too_narrow
      $error("v_multiplexers_hold_reg: SW=%0d cannot address NCH=%0d channels", SW, NCH);
    end
  endgenerate

  localparam logic [SW:0] NCH_L = (SW+1)'(NCH);

  logic         accept;
  logic         mapped;
  logic [W-1:0] sel_dat;

  assign I_READY = !O_VALID || O_READY;
  assign accept  = I_VALID && I_READY;
  assign mapped  = {1'b0, S} < NCH_L;

  // Unmapped codes fall through to zero here, but the output register ignores this value for them.
  always_comb begin
    sel_dat = '0;
    for (int k = 0; k < NCH; k++) begin
      if (S == SW'(k)) sel_dat = DI[k*W +: W];
    end
  end

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      O        <= RESET_VAL;
      O_VALID  <= 1'b0;
      O_HOLD   <= 1'b0;
      MISS_CNT <= '0;
    end else begin
      if (accept) begin
        O_VALID <= 1'b1;
        if (mapped) begin
          O      <= sel_dat;
          O_HOLD <= 1'b0;
        end else begin
          O_HOLD <= 1'b1;
          if (MISS_CNT != '1) MISS_CNT <= MISS_CNT + CW'(1);
        end
      end else if (O_READY) begin
        O_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_v_multiplexers_hold_reg.sv
// Bench for v_multiplexers_hold_reg. It runs directed checks on the default configuration and a CW=2 configuration,
// then a randomized scoreboard run on a W=16, NCH=5, SW=3 configuration.
module tb_v_multiplexers_hold_reg;
  logic C = 1'b0;
  logic CLR = 1'b1;
  always #5 C = ~C;

  // Default and CW=2 instances share stimulus.
  logic [23:0] di;
  logic [1:0]  s;
  logic        iv, ordy;
  logic        ir0, ov0, oh0;
  logic [7:0]  o0, mc0;
  logic        ir1, ov1, oh1;
  logic [7:0]  o1;
  logic [1:0]  mc1;

  // Wide instance for the randomized run.
  logic [79:0] di2;
  logic [2:0]  s2;
  logic        iv2, ordy2;
  logic        ir2, ov2, oh2;
  logic [15:0] o2;
  logic [7:0]  mc2;

  v_multiplexers_hold_reg u_d0 (
    .C(C), .CLR(CLR), .DI(di), .S(s), .I_VALID(iv), .I_READY(ir0),
    .O(o0), .O_VALID(ov0), .O_READY(ordy), .O_HOLD(oh0), .MISS_CNT(mc0));

  v_multiplexers_hold_reg #(.CW(2)) u_d1 (
    .C(C), .CLR(CLR), .DI(di), .S(s), .I_VALID(iv), .I_READY(ir1),
    .O(o1), .O_VALID(ov1), .O_READY(ordy), .O_HOLD(oh1), .MISS_CNT(mc1));

  v_multiplexers_hold_reg #(.W(16), .NCH(5), .SW(3)) u_d2 (
    .C(C), .CLR(CLR), .DI(di2), .S(s2), .I_VALID(iv2), .I_READY(ir2),
    .O(o2), .O_VALID(ov2), .O_READY(ordy2), .O_HOLD(oh2), .MISS_CNT(mc2));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge C);
    #1;
  endtask

  logic [7:0]  exp2 [3] = '{8'h11, 8'h22, 8'h33};
  int          sat_exp [5] = '{1, 2, 3, 3, 3};

  // Reference model for the randomized run: at most one result is outstanding.
  bit          q_v;
  logic [15:0] q_o;
  logic        q_h;
  logic [15:0] cur;
  int          miss;
  bit          mready;

  initial begin
    iv = 0; ordy = 0; di = '0; s = '0;
    iv2 = 0; ordy2 = 0; di2 = '0; s2 = '0;

    #3;
    check("rst_o", o0, 8'h00);
    check("rst_ov", ov0, 0);
    check("rst_oh", oh0, 0);
    check("rst_mc", mc0, 0);

    // The first accept lands on the first edge after CLR falls.
    @(negedge C);
    CLR = 0; ordy = 1; iv = 1; di = {8'h33, 8'h22, 8'h11}; s = 2'd0;
    for (int k = 0; k < 3; k++) begin
      s = 2'(k);
      step();
      check("t2_o", o0, exp2[k]);
      check("t2_ov", ov0, 1);
      check("t2_oh", oh0, 0);
      check("t2_ir", ir0, 1);
    end

    s = 2'd1; step();
    check("t3_o22", o0, 8'h22);
    s = 2'd3; step();
    check("t3_hold_o", o0, 8'h22);
    check("t3_hold_oh", oh0, 1);
    check("t3_hold_mc", mc0, 1);
    check("t3_hold_ov", ov0, 1);
    s = 2'd0; step();
    check("t3_back_o", o0, 8'h11);
    check("t3_back_oh", oh0, 0);

    // Stall: the output must not move while inputs churn.
    ordy = 0;
    for (int k = 0; k < 4; k++) begin
      di = 24'h445566 + 24'(k) * 24'h010203;
      s  = 2'(k);
      #1;
      check("t4_stall_ir", ir0, 0);
      step();
      check("t4_stall_o", o0, 8'h11);
      check("t4_stall_ov", ov0, 1);
    end
    ordy = 1; di = {8'hAA, 8'hBB, 8'hCC}; s = 2'd2;
    #1;
    check("t4_rel_ir", ir0, 1);
    step();
    check("t4_rel_o", o0, 8'hAA);
    check("t4_rel_ov", ov0, 1);
    check("t4_rel_oh", oh0, 0);

    // Asynchronous reset while a result is pending.
    ordy = 0;
    #2;
    CLR = 1;
    #1;
    check("t1_o", o0, 8'h00);
    check("t1_ov", ov0, 0);
    check("t1_oh", oh0, 0);
    check("t1_mc", mc0, 0);

    @(negedge C);
    CLR = 0; iv = 1; ordy = 1; s = 2'd3;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t5_mc", mc1, sat_exp[k]);
      check("t5_o", o1, 8'h00);
      check("t5_oh", oh1, 1);
    end
    iv = 0;

    q_v = 0; q_o = '0; q_h = 0; cur = '0; miss = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      iv2   = ($urandom_range(0, 3) != 0);
      ordy2 = ($urandom_range(0, 3) != 0);
      s2    = 3'($urandom_range(0, 7));
      for (int k = 0; k < 5; k++) di2[k*16 +: 16] = 16'($urandom);
      #1;
      mready = !q_v || ordy2;
      check("rnd_ir", ir2, mready);
      check("rnd_ov", ov2, q_v);
      if (q_v && ordy2) begin
        check("rnd_o", o2, q_o);
        check("rnd_oh", oh2, q_h);
        q_v = 0;
      end
      if (iv2 && mready) begin
        if (int'(s2) < 5) begin
          cur = di2[int'(s2)*16 +: 16];
          q_h = 0;
        end else begin
          q_h = 1;
          if (miss < 255) miss++;
        end
        q_o = cur;
        q_v = 1;
      end
      step();
    end
    check("rnd_mc", mc2, miss);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
